// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised operand stack under rpncalc.
package stack_pkg;

    localparam int unsigned STACK_WIDTH = 16;
    localparam int unsigned STACK_DEPTH = 16;
    localparam int unsigned STACK_CNT_W = 8;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        PUSH  = 3'd1,
        POP   = 3'd2,
        DUP   = 3'd3,
        SWAP  = 3'd4,
        REPL2 = 3'd5,
        CLEAR = 3'd6
    } stack_op_e;

endpackage

// File: rtl/stack_regs.sv
// DEPTH x WIDTH register array with two write ports and read ports at count-1 / count-2.
module stack_regs
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = STACK_WIDTH,
    parameter int unsigned DEPTH = STACK_DEPTH,
    parameter int unsigned CNT_W = STACK_CNT_W,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we0,
    input  logic [AW-1:0]    waddr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] rd_top,
    output logic [WIDTH-1:0] rd_next
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    next_addr;

    // Contents are not reset; the count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[waddr0] <= wdata0;
        end
        if (we1) begin
            mem[waddr1] <= wdata1;
        end
    end

    always_comb begin
        top_addr  = AW'(count - CNT_W'(1));
        next_addr = AW'(count - CNT_W'(2));
        rd_top    = (count == '0) ? '0 : mem[top_addr];
        rd_next   = (count < CNT_W'(2)) ? '0 : mem[next_addr];
    end

endmodule

// File: rtl/param_stack.sv
// LIFO stack with single-cycle PUSH/POP/DUP/SWAP/REPL2/CLEAR and sticky error flags.
module param_stack
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = STACK_WIDTH,
    parameter int unsigned DEPTH = STACK_DEPTH,
    parameter int unsigned CNT_W = STACK_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] val,
    input  logic             err_clr,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] next,
    output logic [CNT_W-1:0] counter,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_set, unf_set;

    logic             we0, we1;
    logic [AW-1:0]    waddr0, waddr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic [AW-1:0]    addr_cnt, addr_m1, addr_m2;
    logic             is_full, is_empty, lt_two;

    assign is_full  = (count_q == DepthCnt);
    assign is_empty = (count_q == '0);
    assign lt_two   = (count_q < CNT_W'(2));
    assign addr_cnt = AW'(count_q);
    assign addr_m1  = AW'(count_q - CNT_W'(1));
    assign addr_m2  = AW'(count_q - CNT_W'(2));

    always_comb begin
        count_d = count_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        we0     = 1'b0;
        we1     = 1'b0;
        waddr0  = addr_cnt;
        waddr1  = addr_m2;
        wdata0  = val;
        wdata1  = top;
        case (op)
            PUSH: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    we0     = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            POP: begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            DUP: begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    we0     = 1'b1;
                    wdata0  = top;
                    count_d = count_q + CNT_W'(1);
                end
            end
            SWAP: begin
                if (lt_two) begin
                    unf_set = 1'b1;
                end else begin
                    we0    = 1'b1;
                    waddr0 = addr_m1;
                    wdata0 = next;
                    we1    = 1'b1;
                end
            end
            REPL2: begin
                if (lt_two) begin
                    unf_set = 1'b1;
                end else begin
                    we0     = 1'b1;
                    waddr0  = addr_m2;
                    count_d = count_q - CNT_W'(1);
                end
            end
            CLEAR:   count_d = '0;
            default: ;
        endcase
        // A new error wins over err_clr on the same edge.
        ovf_d = (ovf_q & ~err_clr) | ovf_set;
        unf_d = (unf_q & ~err_clr) | unf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    stack_regs #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .AW    (AW)
    ) u_regs (
        .clk     (clk),
        .we0     (we0 & ~rst),
        .waddr0  (waddr0),
        .wdata0  (wdata0),
        .we1     (we1 & ~rst),
        .waddr1  (waddr1),
        .wdata1  (wdata1),
        .count   (count_q),
        .rd_top  (top),
        .rd_next (next)
    );

    assign counter = count_q;
    assign full    = is_full;
    assign empty   = is_empty;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench: queue-based reference stack predicts outputs; monitor compares after each edge.
module tb_param_stack;
    import stack_pkg::*;

    localparam int W = 16;
    localparam int D = 4;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] val = '0;
    logic         err_clr = 1'b0;
    logic [W-1:0] top, next;
    logic [C-1:0] counter;
    logic         full, empty, ovf, unf;

    typedef struct packed {
        logic [W-1:0] top;
        logic [W-1:0] nxt;
        logic [C-1:0] cnt;
        logic         full;
        logic         empty;
        logic         ovf;
        logic         unf;
    } exp_t;

    exp_t         exp_q [$];
    logic [W-1:0] model [$];
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;
    int           checks = 0;
    int           errors = 0;
    bit           done = 0;

    param_stack #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
        .clk     (clk),
        .rst     (rst),
        .op      (op),
        .val     (val),
        .err_clr (err_clr),
        .top     (top),
        .next    (next),
        .counter (counter),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf),
        .unf     (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one operation and predict the state visible after the next rising edge.
    task automatic step(input logic r, input logic [2:0] o, input logic [W-1:0] v,
                        input logic ec);
        logic no, nu;
        logic [W-1:0] t;
        exp_t e;
        @(negedge clk);
        rst = r; op = o; val = v; err_clr = ec;
        if (r) begin
            model.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            no = 1'b0;
            nu = 1'b0;
            case (o)
                3'd1: if (model.size() == D) no = 1'b1; else model.push_back(v);
                3'd2: if (model.size() == 0) nu = 1'b1; else void'(model.pop_back());
                3'd3: begin
                    if (model.size() == 0) nu = 1'b1;
                    else if (model.size() == D) no = 1'b1;
                    else model.push_back(model[model.size()-1]);
                end
                3'd4: begin
                    if (model.size() < 2) nu = 1'b1;
                    else begin
                        t = model[model.size()-1];
                        model[model.size()-1] = model[model.size()-2];
                        model[model.size()-2] = t;
                    end
                end
                3'd5: begin
                    if (model.size() < 2) nu = 1'b1;
                    else begin
                        void'(model.pop_back());
                        model[model.size()-1] = v;
                    end
                end
                3'd6: model.delete();
                default: ;
            endcase
            m_ovf = (ec ? 1'b0 : m_ovf) | no;
            m_unf = (ec ? 1'b0 : m_unf) | nu;
        end
        e.top   = (model.size() > 0) ? model[model.size()-1] : '0;
        e.nxt   = (model.size() > 1) ? model[model.size()-2] : '0;
        e.cnt   = C'(model.size());
        e.full  = (model.size() == D);
        e.empty = (model.size() == 0);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per edge at which stimulus was applied.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("top", 32'(top), 32'(e.top));
                check("next", 32'(next), 32'(e.nxt));
                check("counter", 32'(counter), 32'(e.cnt));
                check("full", 32'(full), 32'(e.full));
                check("empty", 32'(empty), 32'(e.empty));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("unf", 32'(unf), 32'(e.unf));
            end
        end
    end

    initial begin
        int r;
        step(1'b1, NOP, '0, 1'b0);
        step(1'b0, PUSH, 16'h0005, 1'b0);
        step(1'b0, PUSH, 16'h0003, 1'b0);
        step(1'b0, SWAP, '0, 1'b0);
        step(1'b0, REPL2, 16'h0008, 1'b0);
        step(1'b1, NOP, '0, 1'b0);
        for (int i = 1; i <= 5; i++) step(1'b0, PUSH, W'(i), 1'b0);
        step(1'b0, NOP, '0, 1'b0);
        step(1'b0, NOP, '0, 1'b1);
        step(1'b0, CLEAR, '0, 1'b0);
        step(1'b0, POP, '0, 1'b0);
        step(1'b0, DUP, '0, 1'b0);
        step(1'b0, PUSH, 16'h0042, 1'b0);
        step(1'b0, SWAP, '0, 1'b0);
        step(1'b0, CLEAR, '0, 1'b1);
        step(1'b0, PUSH, 16'h00AA, 1'b0);
        step(1'b0, DUP, '0, 1'b0);
        step(1'b0, DUP, '0, 1'b0);
        step(1'b0, DUP, '0, 1'b0);
        step(1'b0, DUP, '0, 1'b1);
        step(1'b0, CLEAR, '0, 1'b0);
        step(1'b0, REPL2, 16'h0001, 1'b0);
        step(1'b0, 3'd7, 16'hFFFF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, PUSH, W'($urandom), 1'b0);
        step(1'b1, PUSH, 16'h1234, 1'b0);
        step(1'b0, PUSH, 16'h1234, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            step(r == 0, 3'($urandom_range(0, 7)), W'($urandom), ($urandom_range(0, 9) == 0));
        end
        @(negedge clk);
        op = NOP;
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t: got running expected finished", $time);
        $fatal(1, "timeout");
    end

endmodule
